mac_dot_array: RTL and testbench



---
 rtl/mac_dot_array.sv | 210 +++++++++++++++++++++
 tb/tb_mac_dot_array.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_array.sv
// mac_dot_array
// Multi-lane streaming multiply-accumulate engine for dot-product layers.
// Each lane multiplies its operand pair every accepted beat and accumulates
// the full-precision product into a wide two's-complement accumulator. On
// the last beat of a vector, each lane's sum is shifted with round-half-up,
// then saturated or truncated to OUT_WIDTH, and presented on the output.
//
// Ports:
//   CLK           clock, rising edge
//   RESETN        asynchronous active-low reset
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid && in_ready
//   in_last       final beat of the current vector
//   in_a, in_b    packed per-lane operands, lane i at [i*W +: W]
//   out_valid     result valid
//   out_ready     result consumed when out_valid && out_ready
//   out_data      packed per-lane results, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//   out_overflow  per-lane flag: result clamped, or truncation changed it
//
// Pipeline: S1 operand register -> S2 product register -> S3 accumulator
// register -> output register. One global enable stalls every stage while
// a result sits unconsumed.
module mac_dot_array #(
   parameter int LANES     = 4,
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int A_SIGNED  = 1,
   parameter int B_SIGNED  = 1,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 0,
   parameter int SATURATE  = 1
) (
   input  logic                         CLK,
   input  logic                         RESETN,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [LANES*A_WIDTH-1:0]     in_a,
   input  logic [LANES*B_WIDTH-1:0]     in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*OUT_WIDTH-1:0]   out_data,
   output logic [LANES-1:0]             out_overflow
);

   localparam int PW = A_WIDTH + B_WIDTH;
   // Two guard bits: one for the rounding add, one so the unsigned limit
   // 2^OUT_WIDTH-1 stays positive when OUT_WIDTH == ACC_WIDTH.
   localparam int RW = ACC_WIDTH + 2;
   localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

   localparam logic signed [RW-1:0] ONE   = {{(RW-1){1'b0}}, 1'b1};
   localparam logic signed [RW-1:0] RND   = (ONE <<< SHIFT) >>> 1;
   localparam logic signed [RW-1:0] MAX_V = RES_SIGNED ? (ONE <<< (OUT_WIDTH-1)) - ONE
                                                       : (ONE <<< OUT_WIDTH) - ONE;
   localparam logic signed [RW-1:0] MIN_V = RES_SIGNED ? -(ONE <<< (OUT_WIDTH-1))
                                                       : {RW{1'b0}};

   logic w_en;

   logic                       r_v1;
   logic                       r_last1;
   logic [LANES*A_WIDTH-1:0]   r_a1;
   logic [LANES*B_WIDTH-1:0]   r_b1;

   logic                       r_v2;
   logic                       r_last2;
   logic [PW-1:0]              r_p [LANES];

   logic                       r_v3;
   logic                       r_last3;
   logic                       r_first;
   logic [ACC_WIDTH-1:0]       r_acc [LANES];

   logic                       r_out_valid;
   logic [LANES*OUT_WIDTH-1:0] r_out_data;
   logic [LANES-1:0]           r_out_ovf;

   logic signed [PW-1:0]       w_ax [LANES];
   logic signed [PW-1:0]       w_bx [LANES];
   logic [PW-1:0]              w_p [LANES];
   logic [ACC_WIDTH-1:0]       w_pext [LANES];
   logic [ACC_WIDTH-1:0]       w_acc_new [LANES];
   logic signed [RW-1:0]       w_ext [LANES];
   logic signed [RW-1:0]       w_r [LANES];
   logic signed [RW-1:0]       w_back [LANES];
   logic [OUT_WIDTH-1:0]       w_trunc [LANES];
   logic [LANES*OUT_WIDTH-1:0] w_data;
   logic [LANES-1:0]           w_ovf;

   // A held result freezes the whole pipeline, including input acceptance.
   assign w_en         = !(r_out_valid && !out_ready);
   assign in_ready     = w_en;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_overflow = r_out_ovf;

   // S1: operand capture
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_v1    <= 1'b0;
         r_last1 <= 1'b0;
         r_a1    <= '0;
         r_b1    <= '0;
      end else if (w_en) begin
         r_v1    <= in_valid;
         r_last1 <= in_valid && in_last;
         if (in_valid) begin
            r_a1 <= in_a;
            r_b1 <= in_b;
         end
      end
   end

   // Operands extended to PW bits; the product always fits in PW bits, so
   // a PW-wide multiply gives the exact full-precision result.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_ax[i] = PW'($signed({(A_SIGNED != 0) && r_a1[i*A_WIDTH + A_WIDTH-1],
                                r_a1[i*A_WIDTH +: A_WIDTH]}));
         w_bx[i] = PW'($signed({(B_SIGNED != 0) && r_b1[i*B_WIDTH + B_WIDTH-1],
                                r_b1[i*B_WIDTH +: B_WIDTH]}));
         w_p[i]  = w_ax[i] * w_bx[i];
      end
   end

   // S2: product register
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_v2    <= 1'b0;
         r_last2 <= 1'b0;
         for (int i = 0; i < LANES; i++) r_p[i] <= '0;
      end else if (w_en) begin
         r_v2    <= r_v1;
         r_last2 <= r_last1;
         for (int i = 0; i < LANES; i++) r_p[i] <= w_p[i];
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         if (RES_SIGNED) w_pext[i] = ACC_WIDTH'($signed(r_p[i]));
         else            w_pext[i] = ACC_WIDTH'(r_p[i]);
         w_acc_new[i] = (r_first ? '0 : r_acc[i]) + w_pext[i];
      end
   end

   // S3: accumulate; r_first restarts the sum after every last beat
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_v3    <= 1'b0;
         r_last3 <= 1'b0;
         r_first <= 1'b1;
         for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      end else if (w_en) begin
         r_v3    <= r_v2;
         r_last3 <= r_v2 && r_last2;
         if (r_v2) begin
            r_first <= r_last2;
            for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_new[i];
         end
      end
   end

   // Output scaling: round-half-up shift, then clamp or truncate
   always_comb begin
      w_data = '0;
      w_ovf  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (RES_SIGNED) w_ext[i] = RW'($signed(r_acc[i]));
         else            w_ext[i] = RW'(r_acc[i]);
         w_r[i]     = (w_ext[i] + RND) >>> SHIFT;
         w_trunc[i] = w_r[i][OUT_WIDTH-1:0];
         if (RES_SIGNED) w_back[i] = RW'($signed(w_trunc[i]));
         else            w_back[i] = RW'(w_trunc[i]);
         if (SATURATE != 0) begin
            if (w_r[i] > MAX_V) begin
               w_data[i*OUT_WIDTH +: OUT_WIDTH] = MAX_V[OUT_WIDTH-1:0];
               w_ovf[i] = 1'b1;
            end else if (w_r[i] < MIN_V) begin
               w_data[i*OUT_WIDTH +: OUT_WIDTH] = MIN_V[OUT_WIDTH-1:0];
               w_ovf[i] = 1'b1;
            end else begin
               w_data[i*OUT_WIDTH +: OUT_WIDTH] = w_trunc[i];
            end
         end else begin
            w_data[i*OUT_WIDTH +: OUT_WIDTH] = w_trunc[i];
            w_ovf[i] = (w_back[i] != w_r[i]);
         end
      end
   end

   // Output register: with en high any shown result is being consumed, so a
   // new result may replace it on the same edge.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= '0;
      end else if (w_en) begin
         r_out_valid <= r_v3 && r_last3;
         if (r_v3 && r_last3) begin
            r_out_data <= w_data;
            r_out_ovf  <= w_ovf;
         end
      end
   end

endmodule

// File: tb/tb_mac_dot_array.sv
module tb_mac_dot_array;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        in_valid;
   logic        in_last;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_ready;

   logic        rdy_d, rdy_n, rdy_s;
   logic        val_d, val_n, val_s;
   logic [63:0] dat_d, dat_n, dat_s;
   logic [3:0]  ovf_d, ovf_n, ovf_s;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [63:0] q_dat[$];
   int          q_t[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // default parameters
   mac_dot_array u_def (
      .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid), .in_ready(rdy_d),
      .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(val_d),
      .out_ready(out_ready), .out_data(dat_d), .out_overflow(ovf_d));

   // truncating variant
   mac_dot_array #(.SATURATE(0)) u_nsat (
      .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid), .in_ready(rdy_n),
      .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(val_n),
      .out_ready(out_ready), .out_data(dat_n), .out_overflow(ovf_n));

   // rounding variant
   mac_dot_array #(.SHIFT(2)) u_shf (
      .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid), .in_ready(rdy_s),
      .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(val_s),
      .out_ready(out_ready), .out_data(dat_s), .out_overflow(ovf_s));

   // records every consumed result of the default instance
   always @(negedge CLK) begin
      if (RESETN && val_d && out_ready) begin
         q_dat.push_back(dat_d);
         q_t.push_back(cyc);
      end
   end

   function automatic logic [31:0] pk(input int v0, input int v1, input int v2, input int v3);
      logic [31:0] r;
      r = {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
      return r;
   endfunction

   function automatic int lane(input logic [63:0] d, input int i);
      return int'($signed(d[i*16 +: 16]));
   endfunction

   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
      int   n;
      logic ok;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      n = 0;
      do begin
         @(negedge CLK); ok = rdy_d;
         @(posedge CLK); #1;
         n++;
      end while (!ok && n < 50);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_beat: in_ready=%0b after %0d cycles, expected acceptance", ok, n);
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      do begin @(negedge CLK); n++; end while (!val_d && n < 20);
      checks++;
      if (!val_d) begin
         errors++;
         $display("FAIL %s_timeout: out_valid=%0b after %0d cycles, expected 1", tag, val_d, n);
      end
   endtask

   task automatic test_reset;
      RESETN = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RESETN = 1'b1;
      @(negedge CLK);
      checks++;
      if ({rdy_d, rdy_n, rdy_s} !== 3'b111) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 111", {rdy_d, rdy_n, rdy_s});
      end
      checks++;
      if ({val_d, val_n, val_s} !== 3'b000) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 000", {val_d, val_n, val_s});
      end
      checks++;
      if ({dat_d, dat_n, dat_s} !== '0) begin
         errors++; $display("FAIL reset_out_data: got %h expected 0", dat_d);
      end
      checks++;
      if ({ovf_d, ovf_n, ovf_s} !== 12'h0) begin
         errors++; $display("FAIL reset_overflow: got %h expected 0", {ovf_d, ovf_n, ovf_s});
      end
   endtask

   task automatic test_signed_dot;
      int a0[4] = '{3, -4, 127, -128};
      int b0[4] = '{5, 6, 127, -128};
      int a1[4] = '{1, 2, 3, 4};
      int exp_d[4] = '{32504, 10, -400, 0};
      int exp_s[4] = '{8126, 3, -100, 0};
      @(posedge CLK); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++)
         send_beat(pk(a0[k], a1[k], -1, 0), pk(b0[k], 1, 100, 0), k == 3);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checks++;
         if (val_d !== (k == 3)) begin
            errors++; $display("FAIL dot_latency_edge%0d: out_valid=%0b expected %0b", k, val_d, k == 3);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lane(dat_d, i) !== exp_d[i]) begin
            errors++; $display("FAIL dot_def_lane%0d: got %0d expected %0d", i, lane(dat_d, i), exp_d[i]);
         end
         checks++;
         if (lane(dat_n, i) !== exp_d[i]) begin
            errors++; $display("FAIL dot_nsat_lane%0d: got %0d expected %0d", i, lane(dat_n, i), exp_d[i]);
         end
         checks++;
         if (lane(dat_s, i) !== exp_s[i]) begin
            errors++; $display("FAIL dot_shift_lane%0d: got %0d expected %0d", i, lane(dat_s, i), exp_s[i]);
         end
      end
      checks++;
      if ({ovf_d, ovf_n, ovf_s} !== 12'h0) begin
         errors++; $display("FAIL dot_overflow: got %h expected 0", {ovf_d, ovf_n, ovf_s});
      end
      @(negedge CLK);
      checks++;
      if (val_d !== 1'b0) begin
         errors++; $display("FAIL dot_consumed: out_valid=%0b expected 0", val_d);
      end
   endtask

   task automatic test_saturation;
      int exp_d[4] = '{32767, -32768, 4, 0};
      int exp_n[4] = '{-1020, 512, 4, 0};
      int exp_s[4] = '{16129, -16256, 1, 0};
      @(posedge CLK); #1;
      for (int k = 0; k < 4; k++)
         send_beat(pk(127, -128, 1, 0), pk(127, 127, 1, 0), k == 3);
      wait_out("sat");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lane(dat_d, i) !== exp_d[i]) begin
            errors++; $display("FAIL sat_def_lane%0d: got %0d expected %0d", i, lane(dat_d, i), exp_d[i]);
         end
         checks++;
         if (lane(dat_n, i) !== exp_n[i]) begin
            errors++; $display("FAIL sat_trunc_lane%0d: got %0d expected %0d", i, lane(dat_n, i), exp_n[i]);
         end
         checks++;
         if (lane(dat_s, i) !== exp_s[i]) begin
            errors++; $display("FAIL sat_shift_lane%0d: got %0d expected %0d", i, lane(dat_s, i), exp_s[i]);
         end
      end
      checks++;
      if (ovf_d !== 4'b0011) begin
         errors++; $display("FAIL sat_def_overflow: got %b expected 0011", ovf_d);
      end
      checks++;
      if (ovf_n !== 4'b0011) begin
         errors++; $display("FAIL sat_trunc_overflow: got %b expected 0011", ovf_n);
      end
      checks++;
      if (ovf_s !== 4'b0000) begin
         errors++; $display("FAIL sat_shift_overflow: got %b expected 0000", ovf_s);
      end
   endtask

   task automatic test_rounding;
      int exp_d[4] = '{9, -9, 6, -6};
      int exp_s[4] = '{2, -2, 2, -1};
      @(posedge CLK); #1;
      send_beat(pk(3, -3, 2, -2), pk(3, 3, 3, 3), 1'b1);
      wait_out("round");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lane(dat_d, i) !== exp_d[i]) begin
            errors++; $display("FAIL round_def_lane%0d: got %0d expected %0d", i, lane(dat_d, i), exp_d[i]);
         end
         checks++;
         if (lane(dat_s, i) !== exp_s[i]) begin
            errors++; $display("FAIL round_shift_lane%0d: got %0d expected %0d", i, lane(dat_s, i), exp_s[i]);
         end
      end
      checks++;
      if (ovf_s !== 4'b0000) begin
         errors++; $display("FAIL round_overflow: got %b expected 0000", ovf_s);
      end
   endtask

   task automatic test_bubbles;
      @(posedge CLK); #1;
      q_dat.delete(); q_t.delete();
      send_beat(pk(2, 1, 0, 0), pk(5, 1, 0, 0), 1'b0);
      in_last = 1'b1; in_a = 32'h7F7F7F7F; in_b = 32'h7F7F7F7F;
      repeat (2) begin @(posedge CLK); #1; end
      send_beat(pk(3, 1, 0, 0), pk(5, 1, 0, 0), 1'b0);
      in_last = 1'b1; in_a = 32'h81818181;
      repeat (2) begin @(posedge CLK); #1; end
      send_beat(pk(4, 1, 0, 0), pk(5, 1, 0, 0), 1'b1);
      wait_out("bubble");
      checks++;
      if (lane(dat_d, 0) !== 45 || lane(dat_d, 1) !== 3) begin
         errors++; $display("FAIL bubble_data: got %0d,%0d expected 45,3", lane(dat_d, 0), lane(dat_d, 1));
      end
      repeat (6) begin @(posedge CLK); #1; end
      checks++;
      if (q_dat.size() !== 1) begin
         errors++; $display("FAIL bubble_count: got %0d results expected 1", q_dat.size());
      end
   endtask

   task automatic test_back_to_back;
      int e0[3] = '{10, 20, 30};
      @(posedge CLK); #1;
      out_ready = 1'b1;
      q_dat.delete(); q_t.delete();
      for (int k = 0; k < 3; k++)
         send_beat(pk(k + 1, -(k + 1), 0, 0), pk(10, 10, 0, 0), 1'b1);
      repeat (8) begin @(posedge CLK); #1; end
      checks++;
      if (q_dat.size() !== 3) begin
         errors++; $display("FAIL b2b_count: got %0d results expected 3", q_dat.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (lane(q_dat[j], 0) !== e0[j] || lane(q_dat[j], 1) !== -e0[j]) begin
               errors++;
               $display("FAIL b2b_result%0d: got %0d,%0d expected %0d,%0d", j,
                        lane(q_dat[j], 0), lane(q_dat[j], 1), e0[j], -e0[j]);
            end
         end
         checks++;
         if (q_t[1] - q_t[0] !== 1 || q_t[2] - q_t[1] !== 1) begin
            errors++; $display("FAIL b2b_spacing: got gaps %0d,%0d expected 1,1", q_t[1] - q_t[0], q_t[2] - q_t[1]);
         end
      end
   endtask

   task automatic test_backpressure;
      int expq[3][4] = '{'{11, -21, 2, 0}, '{41, 0, 8, 0}, '{9, -49, 0, 10000}};
      @(posedge CLK); #1;
      out_ready = 1'b0;
      q_dat.delete(); q_t.delete();
      send_beat(pk(1, -1, 1, 0),    pk(3, 7, 1, 0),     1'b0);
      send_beat(pk(2, -2, 1, 0),    pk(4, 7, 1, 0),     1'b1);
      send_beat(pk(4, 10, 2, 0),    pk(4, 10, 2, 0),    1'b0);
      send_beat(pk(5, -10, 2, 0),   pk(5, 10, 2, 0),    1'b1);
      send_beat(pk(3, -7, 0, 100),  pk(3, 7, 0, 100),   1'b1);
      wait_out("bp");
      checks++;
      if (rdy_d !== 1'b0) begin
         errors++; $display("FAIL bp_in_ready_drop: got %0b expected 0", rdy_d);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         checks++;
         if (val_d !== 1'b1 || rdy_d !== 1'b0 || lane(dat_d, 0) !== 11 || lane(dat_d, 1) !== -21) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%0b ready=%0b data=%0d,%0d expected 1,0,11,-21",
                     k, val_d, rdy_d, lane(dat_d, 0), lane(dat_d, 1));
         end
      end
      @(posedge CLK); #1;
      out_ready = 1'b1;
      repeat (8) begin @(posedge CLK); #1; end
      checks++;
      if (q_dat.size() !== 3) begin
         errors++; $display("FAIL bp_count: got %0d results expected 3", q_dat.size());
      end else begin
         for (int j = 0; j < 3; j++)
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (lane(q_dat[j], i) !== expq[j][i]) begin
                  errors++;
                  $display("FAIL bp_result%0d_lane%0d: got %0d expected %0d", j, i, lane(q_dat[j], i), expq[j][i]);
               end
            end
      end
   endtask

   task automatic test_reset_mid;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      q_dat.delete(); q_t.delete();
      send_beat(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b1);
      send_beat(pk(50, 50, 50, 50), pk(50, 50, 50, 50), 1'b0);
      send_beat(pk(50, 50, 50, 50), pk(50, 50, 50, 50), 1'b0);
      RESETN = 1'b0;
      @(negedge CLK);
      checks++;
      if ({val_d, val_n, val_s} !== 3'b000 || {rdy_d, rdy_n, rdy_s} !== 3'b111 || dat_d !== '0) begin
         errors++;
         $display("FAIL midreset_state: valid=%b ready=%b data=%h expected 000,111,0",
                  {val_d, val_n, val_s}, {rdy_d, rdy_n, rdy_s}, dat_d);
      end
      repeat (2) @(posedge CLK);
      #1 RESETN = 1'b1;
      out_ready = 1'b1;
      send_beat(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b1);
      wait_out("midreset");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lane(dat_d, i) !== 6) begin
            errors++; $display("FAIL midreset_lane%0d: got %0d expected 6", i, lane(dat_d, i));
         end
      end
      checks++;
      if (ovf_d !== 4'b0000) begin
         errors++; $display("FAIL midreset_overflow: got %b expected 0000", ovf_d);
      end
      repeat (6) begin @(posedge CLK); #1; end
      checks++;
      if (q_dat.size() !== 1) begin
         errors++; $display("FAIL midreset_count: got %0d results expected 1", q_dat.size());
      end
   endtask

   initial begin
      test_reset();
      test_signed_dot();
      test_saturation();
      test_rounding();
      test_bubbles();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit reached");
   end

endmodule
